// File: rtl/adbg_pkg.sv
// Shared constants and types for the advanced debug interface.
// Holds module ID encodings and select-command geometry.
package adbg_pkg;

  localparam int DBG_TOP_MAX_MODULES       = 4;
  localparam int DBG_TOP_MODULE_ID_LENGTH  = 2;
  localparam int DBG_TOP_CMD_LEN           = 1 + DBG_TOP_MODULE_ID_LENGTH;

  typedef logic [DBG_TOP_MODULE_ID_LENGTH-1:0] module_id_t;

  localparam module_id_t DBG_TOP_BUSIF_DEBUG_MODULE    = 2'd0;
  localparam module_id_t DBG_TOP_CPU_DEBUG_MODULE      = 2'd1;
  localparam module_id_t DBG_TOP_JSP_DEBUG_MODULE      = 2'd2;
  localparam module_id_t DBG_TOP_RESERVED_DEBUG_MODULE = 2'd3;

endpackage

// File: rtl/adbg_module_select.sv
// JTAG-side module-select controller: decodes select commands and routes TDO.
// Optional sticky select-error status is enabled by defining ADBG_SELECT_ERR_EN.
module adbg_module_select
  import adbg_pkg::*;
#(
  parameter int MAX_MODULES = DBG_TOP_MAX_MODULES,
  parameter int ID_LEN      = DBG_TOP_MODULE_ID_LENGTH,
  parameter int CMD_LEN     = 1 + ID_LEN
) (
  input  logic                   tck_i,
  input  logic                   rst_i,
  input  logic                   debug_select_i,
  input  logic                   capture_dr_i,
  input  logic                   shift_dr_i,
  input  logic                   update_dr_i,
  input  logic                   tdi_i,
  output logic                   tdo_o,
  input  logic [MAX_MODULES-1:0] module_present_i,
  input  logic [MAX_MODULES-1:0] module_tdo_i,
  output logic [MAX_MODULES-1:0] module_select_o,
  output logic [ID_LEN-1:0]      module_id_o
);

  localparam int CNT_W = $clog2(CMD_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_LEN);

  logic [ID_LEN-1:0] id_q, id_d;
  logic [ID_LEN-1:0] id_sr_q, id_sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              valid_q, valid_d;
  logic              cmd_flag_q, cmd_flag_d;
  logic              sel_err_q, sel_err_d;

  logic cap_s, upd_s, shf_s;
  logic cmd_accept_s;
  logic status_s;

  // Strobes qualified by the DEBUG instruction; capture > update > shift.
  assign cap_s = debug_select_i & capture_dr_i;
  assign upd_s = debug_select_i & update_dr_i & ~capture_dr_i;
  assign shf_s = debug_select_i & shift_dr_i & ~capture_dr_i & ~update_dr_i;

  assign cmd_accept_s = upd_s & cmd_flag_q & (bit_cnt_q == CNT_FULL);

  // Next-state logic for the command shifter and latched selection.
  always_comb begin
    id_d       = id_q;
    id_sr_d    = id_sr_q;
    bit_cnt_d  = bit_cnt_q;
    valid_d    = valid_q;
    cmd_flag_d = cmd_flag_q;
    sel_err_d  = sel_err_q;
    if (cap_s) begin
      bit_cnt_d  = {CNT_W{1'b0}};
      cmd_flag_d = 1'b0;
    end else if (upd_s) begin
      if (cmd_accept_s) begin
        id_d      = id_sr_q;
        valid_d   = module_present_i[id_sr_q];
        sel_err_d = ~module_present_i[id_sr_q];
      end else begin
        id_d = id_q;
      end
    end else if (shf_s) begin
      if (bit_cnt_q == {CNT_W{1'b0}}) begin
        cmd_flag_d = tdi_i;
      end else begin
        for (int i = 0; i < ID_LEN; i++) begin
          if (bit_cnt_q == CNT_W'(i + 1)) begin
            id_sr_d[i] = tdi_i;
          end else begin
            id_sr_d[i] = id_sr_q[i];
          end
        end
      end
      if (bit_cnt_q < CNT_FULL) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      id_q       <= {ID_LEN{1'b0}};
      id_sr_q    <= {ID_LEN{1'b0}};
      bit_cnt_q  <= {CNT_W{1'b0}};
      valid_q    <= 1'b0;
      cmd_flag_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      id_q       <= id_d;
      id_sr_q    <= id_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      valid_q    <= valid_d;
      cmd_flag_q <= cmd_flag_d;
      sel_err_q  <= sel_err_d;
    end
  end

`ifdef ADBG_SELECT_ERR_EN
  assign status_s = sel_err_q;
`else
  assign status_s = 1'b0;
`endif

  // Selects and TDO are derived from registers; selects drop during command scans.
  always_comb begin
    module_select_o = {MAX_MODULES{1'b0}};
    tdo_o           = 1'b0;
    if (valid_q && !cmd_flag_q) begin
      module_select_o = MAX_MODULES'(1) << id_q;
    end else begin
      module_select_o = {MAX_MODULES{1'b0}};
    end
    if (cmd_flag_q) begin
      tdo_o = status_s;
    end else if (valid_q) begin
      tdo_o = module_tdo_i[id_q];
    end else begin
      tdo_o = 1'b0;
    end
  end

  assign module_id_o = id_q;

endmodule

// File: tb/tb_adbg_module_select.sv
// Directed self-checking bench for adbg_module_select.
// Status-bit expectations follow ADBG_SELECT_ERR_EN when defined.
module tb_adbg_module_select;

  logic       tck_i = 1'b0;
  logic       rst_i;
  logic       debug_select_i;
  logic       capture_dr_i;
  logic       shift_dr_i;
  logic       update_dr_i;
  logic       tdi_i;
  logic       tdo_o;
  logic [3:0] module_present_i;
  logic [3:0] module_tdo_i;
  logic [3:0] module_select_o;
  logic [1:0] module_id_o;

  int total = 0;
  int bad   = 0;

`ifdef ADBG_SELECT_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  adbg_module_select dut (
    .tck_i            (tck_i),
    .rst_i            (rst_i),
    .debug_select_i   (debug_select_i),
    .capture_dr_i     (capture_dr_i),
    .shift_dr_i       (shift_dr_i),
    .update_dr_i      (update_dr_i),
    .tdi_i            (tdi_i),
    .tdo_o            (tdo_o),
    .module_present_i (module_present_i),
    .module_tdo_i     (module_tdo_i),
    .module_select_o  (module_select_o),
    .module_id_o      (module_id_o)
  );

  always #5 tck_i = ~tck_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tck_i);
    #1;
  endtask

  task automatic capture();
    capture_dr_i = 1'b1;
    step();
    capture_dr_i = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    shift_dr_i = 1'b1;
    tdi_i      = b;
    step();
    shift_dr_i = 1'b0;
  endtask

  task automatic update();
    update_dr_i = 1'b1;
    step();
    update_dr_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; debug_select_i = 1'b1; capture_dr_i = 1'b0; shift_dr_i = 1'b0;
    update_dr_i = 1'b0; tdi_i = 1'b0; module_present_i = 4'b0111; module_tdo_i = 4'b1010;

    // 1. reset
    step(); step();
    rst_i = 1'b0;
    check("rst_sel", 32'(module_select_o), 32'h0);
    check("rst_tdo", 32'(tdo_o), 32'h0);
    check("rst_id", 32'(module_id_o), 32'h0);

    // 2. select CPU: flag 1, id LSB first 1,0
    capture(); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0); update();
    check("cpu_id", 32'(module_id_o), 32'h1);
    capture();
    check("cpu_sel", 32'(module_select_o), 32'h2);
    check("cpu_tdo_hi", 32'(tdo_o), 32'h1);
    shift_bit(1'b0);
    module_tdo_i = 4'b1101; #1;
    check("cpu_tdo_lo", 32'(tdo_o), 32'h0);
    module_tdo_i = 4'b1010; #1;
    check("cpu_tdo_back", 32'(tdo_o), 32'h1);

    // 3. absent module 3, then JSP
    capture(); shift_bit(1'b1);
    check("abs_sel_drop", 32'(module_select_o), 32'h0);
    check("abs_tdo_status0", 32'(tdo_o), 32'h0);
    shift_bit(1'b1); shift_bit(1'b1); update();
    check("abs_id", 32'(module_id_o), 32'h3);
    check("abs_sel", 32'(module_select_o), 32'h0);
    capture();
    check("abs_tdo_data", 32'(tdo_o), 32'h0);
    check("abs_sel_after_cap", 32'(module_select_o), 32'h0);
    shift_bit(1'b1);
    check("abs_err_status", 32'(tdo_o), 32'(ERR_EN));
    shift_bit(1'b0); shift_bit(1'b1); update();
    check("jsp_err_clear", 32'(tdo_o), 32'h0);
    check("jsp_id", 32'(module_id_o), 32'h2);
    capture();
    check("jsp_sel", 32'(module_select_o), 32'h4);
    check("jsp_tdo", 32'(tdo_o), 32'h0);

    // reselect CPU with extra bits beyond the command length
    capture(); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    shift_bit(1'b1); shift_bit(1'b1); update();
    check("sat_id", 32'(module_id_o), 32'h1);

    // 4. short and zero-length commands are discarded
    capture();
    check("short_sel_pre", 32'(module_select_o), 32'h2);
    shift_bit(1'b1);
    check("short_sel_low", 32'(module_select_o), 32'h0);
    shift_bit(1'b0); update();
    check("short_id", 32'(module_id_o), 32'h1);
    capture(); update();
    check("zero_len_id", 32'(module_id_o), 32'h1);
    capture(); shift_bit(1'b0);
    check("short_sel_back", 32'(module_select_o), 32'h2);

    // 5. unqualified strobes change nothing
    debug_select_i = 1'b0;
    capture(); shift_bit(1'b1);
    check("gate_shift_sel", 32'(module_select_o), 32'h2);
    shift_bit(1'b0); shift_bit(1'b0); update();
    debug_select_i = 1'b1;
    check("gate_sel", 32'(module_select_o), 32'h2);
    check("gate_id", 32'(module_id_o), 32'h1);

    // 6. reset mid-scan aborts it
    capture(); shift_bit(1'b1); shift_bit(1'b1);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    update();
    check("mid_rst_sel", 32'(module_select_o), 32'h0);
    check("mid_rst_id", 32'(module_id_o), 32'h0);
    check("mid_rst_tdo", 32'(tdo_o), 32'h0);

    // capture beats update in the same cycle
    capture(); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
    capture_dr_i = 1'b1; update_dr_i = 1'b1; step();
    capture_dr_i = 1'b0; update_dr_i = 1'b0;
    check("prio_cap_id", 32'(module_id_o), 32'h0);
    update();
    check("prio_cap_id2", 32'(module_id_o), 32'h0);

    // update beats shift in the same cycle
    capture(); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
    update_dr_i = 1'b1; shift_dr_i = 1'b1; tdi_i = 1'b0; step();
    update_dr_i = 1'b0; shift_dr_i = 1'b0;
    check("prio_upd_id", 32'(module_id_o), 32'h2);
    capture();
    check("prio_upd_sel", 32'(module_select_o), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
